// File: rtl/traffic_light_fsm.sv
// Moore intersection controller: main/side greens, yellows and a walk phase,
// paced by an external timer via start_timer/interval/expired.
module traffic_light_fsm (
    input  logic       clk,
    input  logic       Reset_Sync,
    input  logic       Sensor_Sync,
    input  logic       WR,
    input  logic       Prog_Sync,
    input  logic       expired,
    output logic       WR_Reset,
    output logic [6:0] LEDs,
    output logic [1:0] interval,
    output logic       start_timer
);

    typedef enum logic [2:0] {
        MG1  = 3'd0,
        MG2  = 3'd1,
        MY   = 3'd2,
        WALK = 3'd3,
        SG1  = 3'd4,
        SG2  = 3'd5,
        SY   = 3'd6
    } state_t;

    localparam logic [6:0] LED_MG   = 7'b0011000;
    localparam logic [6:0] LED_MY   = 7'b0101000;
    localparam logic [6:0] LED_WALK = 7'b1001001;
    localparam logic [6:0] LED_SG   = 7'b1000010;
    localparam logic [6:0] LED_SY   = 7'b1000100;

    localparam logic [1:0] T_BASE = 2'b00;
    localparam logic [1:0] T_EXT  = 2'b01;
    localparam logic [1:0] T_YEL  = 2'b10;

    state_t state;
    state_t state_n;
    logic   ext_flag;
    logic   ext_n;
    logic   start_n;
    logic   advance;

    always_ff @(posedge clk) begin
        if (!Reset_Sync) begin
            state       <= MG1;
            start_timer <= 1'b1;
            ext_flag    <= 1'b0;
        end else begin
            state       <= state_n;
            start_timer <= start_n;
            ext_flag    <= ext_n;
        end
    end

    // A stale expired level is ignored during the restart pulse.
    assign advance = expired && !start_timer;

    always_comb begin
        state_n = state;
        start_n = advance;
        ext_n   = ext_flag;
        if (Prog_Sync) begin
            state_n = MG1;
            start_n = 1'b1;
            ext_n   = 1'b0;
        end else begin
            case (state)
                MG1: begin
                    if (advance) begin
                        state_n = MG2;
                        ext_n   = Sensor_Sync;
                    end
                end
                MG2: begin
                    if (advance) state_n = MY;
                end
                MY: begin
                    if (advance) state_n = WR ? WALK : SG1;
                end
                WALK: begin
                    if (advance) state_n = SG1;
                end
                SG1: begin
                    if (advance) state_n = Sensor_Sync ? SG2 : SY;
                end
                SG2: begin
                    if (advance) state_n = SY;
                end
                SY: begin
                    if (advance) state_n = MG1;
                end
                default: begin
                    state_n = MG1;
                    start_n = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        LEDs     = LED_MG;
        interval = T_BASE;
        WR_Reset = 1'b0;
        case (state)
            MG1: begin
                LEDs     = LED_MG;
                interval = T_BASE;
            end
            MG2: begin
                LEDs     = LED_MG;
                interval = ext_flag ? T_EXT : T_BASE;
            end
            MY: begin
                LEDs     = LED_MY;
                interval = T_YEL;
            end
            WALK: begin
                LEDs     = LED_WALK;
                interval = T_EXT;
                WR_Reset = 1'b1;
            end
            SG1: begin
                LEDs     = LED_SG;
                interval = T_BASE;
            end
            SG2: begin
                LEDs     = LED_SG;
                interval = T_EXT;
            end
            SY: begin
                LEDs     = LED_SY;
                interval = T_YEL;
            end
            default: begin
                LEDs     = LED_MG;
                interval = T_BASE;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: phase sequences, walk, sensor
// extension, stale expired, reprogram and reset from WALK.
module tb_traffic_light_fsm;

    logic       clk = 1'b0;
    logic       Reset_Sync = 1'b0;
    logic       Sensor_Sync = 1'b0;
    logic       WR = 1'b0;
    logic       Prog_Sync = 1'b0;
    logic       expired = 1'b0;
    logic       WR_Reset;
    logic [6:0] LEDs;
    logic [1:0] interval;
    logic       start_timer;

    int checks = 0;
    int passes = 0;

    localparam logic [6:0] L_MG = 7'b0011000;
    localparam logic [6:0] L_MY = 7'b0101000;
    localparam logic [6:0] L_WK = 7'b1001001;
    localparam logic [6:0] L_SG = 7'b1000010;
    localparam logic [6:0] L_SY = 7'b1000100;

    traffic_light_fsm dut (
        .clk(clk),
        .Reset_Sync(Reset_Sync),
        .Sensor_Sync(Sensor_Sync),
        .WR(WR),
        .Prog_Sync(Prog_Sync),
        .expired(expired),
        .WR_Reset(WR_Reset),
        .LEDs(LEDs),
        .interval(interval),
        .start_timer(start_timer)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] l,
                       input logic [1:0] iv, input logic st,
                       input logic wrr);
        checks++;
        assert (LEDs === l) passes++;
        else $error("FAIL %s LEDs got=%b exp=%b", tag, LEDs, l);
        checks++;
        assert (interval === iv) passes++;
        else $error("FAIL %s interval got=%b exp=%b", tag, interval, iv);
        checks++;
        assert (start_timer === st) passes++;
        else $error("FAIL %s start_timer got=%b exp=%b", tag, start_timer, st);
        checks++;
        assert (WR_Reset === wrr) passes++;
        else $error("FAIL %s WR_Reset got=%b exp=%b", tag, WR_Reset, wrr);
    endtask

    // One-cycle expired pulse, then check entry cycle and following hold cycle
    task automatic adv(input string tag, input logic [6:0] l,
                       input logic [1:0] iv, input logic wrr);
        expired = 1'b1;
        step();
        expired = 1'b0;
        chk({tag, "_entry"}, l, iv, 1'b1, wrr);
        step();
        chk({tag, "_hold"}, l, iv, 1'b0, wrr);
    endtask

    initial begin
        // reset
        step();
        chk("reset", L_MG, 2'b00, 1'b1, 1'b0);
        Reset_Sync = 1'b1;
        step();
        chk("reset_rel", L_MG, 2'b00, 1'b0, 1'b0);

        // plain cycle
        adv("p_mg2", L_MG, 2'b00, 1'b0);
        adv("p_my", L_MY, 2'b10, 1'b0);
        adv("p_sg1", L_SG, 2'b00, 1'b0);
        adv("p_sy", L_SY, 2'b10, 1'b0);
        adv("p_mg1", L_MG, 2'b00, 1'b0);

        // walk request
        WR = 1'b1;
        adv("w_mg2", L_MG, 2'b00, 1'b0);
        adv("w_my", L_MY, 2'b10, 1'b0);
        adv("w_walk", L_WK, 2'b01, 1'b1);
        WR = 1'b0;
        adv("w_sg1", L_SG, 2'b00, 1'b0);
        adv("w_sy", L_SY, 2'b10, 1'b0);
        adv("w_mg1", L_MG, 2'b00, 1'b0);

        // sensor held
        Sensor_Sync = 1'b1;
        adv("s_mg2", L_MG, 2'b01, 1'b0);
        adv("s_my", L_MY, 2'b10, 1'b0);
        adv("s_sg1", L_SG, 2'b00, 1'b0);
        adv("s_sg2", L_SG, 2'b01, 1'b0);
        adv("s_sy", L_SY, 2'b10, 1'b0);
        adv("s_mg1", L_MG, 2'b00, 1'b0);
        Sensor_Sync = 1'b0;

        // reprogram beats expired
        adv("g_mg2", L_MG, 2'b00, 1'b0);
        adv("g_my", L_MY, 2'b10, 1'b0);
        adv("g_sg1", L_SG, 2'b00, 1'b0);
        Prog_Sync = 1'b1;
        expired = 1'b1;
        step();
        chk("prog", L_MG, 2'b00, 1'b1, 1'b0);
        Prog_Sync = 1'b0;
        expired = 1'b0;
        step();
        chk("prog_hold", L_MG, 2'b00, 1'b0, 1'b0);

        // reset while in WALK
        adv("r_mg2", L_MG, 2'b00, 1'b0);
        adv("r_my", L_MY, 2'b10, 1'b0);
        WR = 1'b1;
        adv("r_walk", L_WK, 2'b01, 1'b1);
        WR = 1'b0;
        Reset_Sync = 1'b0;
        step();
        chk("rst_walk", L_MG, 2'b00, 1'b1, 1'b0);

        // expired held 3 cycles starting under the reset pulse
        Reset_Sync = 1'b1;
        expired = 1'b1;
        step();
        chk("stale_1", L_MG, 2'b00, 1'b0, 1'b0);
        step();
        chk("stale_2", L_MG, 2'b00, 1'b1, 1'b0);
        step();
        chk("stale_3", L_MG, 2'b00, 1'b0, 1'b0);
        expired = 1'b0;
        step();
        chk("stale_4", L_MG, 2'b00, 1'b0, 1'b0);
        // still MG2: one more pulse must reach MY, not SG1
        adv("stale_my", L_MY, 2'b10, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
